// File: rtl/pixel_streamer_if.sv
// Host write port, stream control and raster pixel stream of pixel_streamer.
// master = the streamer itself; slave = the host/consumer side.
interface pixel_streamer_if #(
  parameter int ADDR_W = 12
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic              pause;
  logic [7:0]        pixel;
  logic              pixel_valid;
  logic              line_end;
  logic              frame_end;
  logic              busy;
  logic              done;

  modport master (
    input  wr_en, wr_addr, wr_data, start, pause,
    output pixel, pixel_valid, line_end, frame_end, busy, done
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start, pause,
    input  pixel, pixel_valid, line_end, frame_end, busy, done
  );
endinterface

// File: rtl/pixel_streamer.sv
// Frame-memory pixel source: a host loads a WIDTH x HEIGHT 8-bit frame, and start
// replays it in raster order with HBLANK idle cycles between lines.
module pixel_streamer #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int HBLANK = 4,
  parameter int ADDR_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  pixel_streamer_if.master bus
);
  localparam int DEPTH      = WIDTH * HEIGHT;
  localparam int MW         = $clog2(DEPTH);
  localparam int XW         = $clog2(WIDTH);
  localparam int YW         = $clog2(HEIGHT);
  localparam int BW         = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam int BLANK_LAST = (HBLANK > 0) ? HBLANK - 1 : 0;

  typedef enum logic [1:0] {IDLE, STREAM, BLANK, FINISH} state_t;

  state_t        state, state_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [MW-1:0] addr, addr_n;

  logic [7:0] mem [DEPTH];
  logic [7:0] pixel_q;
  logic       pixel_valid_q, line_end_q, frame_end_q, busy_q, done_q;
  logic       rd_en, last_x, last_y, wr_ok;

  assign last_x = (x == XW'(WIDTH - 1));
  assign last_y = (y == YW'(HEIGHT - 1));
  // Out-of-range addresses are dropped here so their low bits never alias a real pixel.
  assign wr_ok  = bus.wr_en && !busy_q &&
                  ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(DEPTH));

  // The read address runs as a raster counter, equal to y*WIDTH+x without a multiplier.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_n = state;
    x_n     = x;
    y_n     = y;
    bcnt_n  = bcnt;
    addr_n  = addr;
    rd_en   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = STREAM;
          x_n     = '0;
          y_n     = '0;
          addr_n  = '0;
        end
      end
      STREAM: begin
        if (!bus.pause) begin
          rd_en  = 1'b1;
          addr_n = addr + MW'(1);
          if (!last_x) begin
            x_n = x + XW'(1);
          end else if (last_y) begin
            state_n = FINISH;
          end else if (HBLANK == 0) begin
            x_n = '0;
            y_n = y + YW'(1);
          end else begin
            state_n = BLANK;
            bcnt_n  = '0;
          end
        end
      end
      BLANK: begin
        if (!bus.pause) begin
          if (bcnt == BW'(BLANK_LAST)) begin
            state_n = STREAM;
            x_n     = '0;
            y_n     = y + YW'(1);
          end else begin
            bcnt_n = bcnt + BW'(1);
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      bcnt          <= '0;
      addr          <= '0;
      pixel_valid_q <= 1'b0;
      line_end_q    <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_n;
      x             <= x_n;
      y             <= y_n;
      bcnt          <= bcnt_n;
      addr          <= addr_n;
      pixel_valid_q <= rd_en;
      line_end_q    <= rd_en && last_x;
      frame_end_q   <= rd_en && last_x && last_y;
      busy_q        <= (state_n != IDLE);
      done_q        <= (state == FINISH);
    end
  end

  // NOTE: the frame store has no reset; a reset must leave the loaded frame intact.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.wr_addr[MW-1:0]] <= bus.wr_data;
  end

  // The pixel register doubles as the memory read register and holds between reads.
  always_ff @(posedge clk) begin
    if (reset)      pixel_q <= '0;
    else if (rd_en) pixel_q <= mem[addr];
  end

  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.line_end    = line_end_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer: a 4x3 frame with HBLANK=2 (dut a) and
// HBLANK=0 (dut b); cycle k is the interval that ends with rising edge k.
module tb_pixel_streamer;
  localparam int W     = 4;
  localparam int H     = 3;
  localparam int NPIX  = W * H;
  localparam int HB_A  = 2;
  localparam int HB_B  = 0;
  localparam int TB_AW = 5;

  typedef struct {
    int dev;
    int val;
    int cyc;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc = 1;
  logic rst_seen = 1'b1;
  bit   mon_on = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  ev_t pix_q[$];
  ev_t done_q[$];
  ev_t busy_q[$];

  pixel_streamer_if #(.ADDR_W(TB_AW)) bus_a ();
  pixel_streamer_if #(.ADDR_W(TB_AW)) bus_b ();

  pixel_streamer #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB_A), .ADDR_W(TB_AW)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  pixel_streamer #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB_B), .ADDR_W(TB_AW)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  logic [7:0] m_pix [2];
  logic       m_valid [2], m_le [2], m_fe [2], m_busy [2], m_done [2];
  logic [7:0] last_pix [2];
  logic       prev_busy [2];

  assign m_pix[0]   = bus_a.pixel;       assign m_pix[1]   = bus_b.pixel;
  assign m_valid[0] = bus_a.pixel_valid; assign m_valid[1] = bus_b.pixel_valid;
  assign m_le[0]    = bus_a.line_end;    assign m_le[1]    = bus_b.line_end;
  assign m_fe[0]    = bus_a.frame_end;   assign m_fe[1]    = bus_b.frame_end;
  assign m_busy[0]  = bus_a.busy;        assign m_busy[1]  = bus_b.busy;
  assign m_done[0]  = bus_a.done;        assign m_done[1]  = bus_b.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected frame: mem[i] = i+16, line period W+hb, pixels at or after pidx delayed by plen.
  task automatic push_frame(input int d, input int t0, input int hb, input int pidx,
                            input int plen, input int n);
    int lastc = 0;
    for (int i = 0; i < n; i++) begin
      ev_t e;
      e.dev = d;
      e.val = (i + 16) + ((i % W == W - 1) ? 256 : 0) + ((i == NPIX - 1) ? 512 : 0);
      e.cyc = t0 + 2 + (i / W) * (W + hb) + (i % W) + ((i >= pidx) ? plen : 0);
      pix_q.push_back(e);
      lastc = e.cyc;
    end
    busy_q.push_back('{dev: d, val: 1, cyc: t0 + 1});
    busy_q.push_back('{dev: d, val: 0, cyc: lastc + 1});
    if (n == NPIX) done_q.push_back('{dev: d, val: 1, cyc: lastc + 1});
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    int  val;
    if (mon_on) begin
      for (int d = 0; d < 2; d++) begin
        if (m_valid[d]) begin
          ok = pix_q.size() > 0;
          if (ok) ok = (pix_q[0].dev == d);
          check($sformatf("dev%0d pixel expected", d), int'(ok), 1);
          if (ok) begin
            e   = pix_q.pop_front();
            val = int'(m_pix[d]) + (m_le[d] ? 256 : 0) + (m_fe[d] ? 512 : 0);
            check($sformatf("dev%0d pixel+256*line_end+512*frame_end", d), val, e.val);
            check($sformatf("dev%0d pixel cycle", d), cyc, e.cyc);
          end
        end else begin
          check($sformatf("dev%0d flags while invalid", d), int'({m_le[d], m_fe[d]}), 0);
          check($sformatf("dev%0d pixel hold", d), int'(m_pix[d]),
                rst_seen ? 0 : int'(last_pix[d]));
        end
        last_pix[d] = m_pix[d];

        if (m_done[d]) begin
          ok = done_q.size() > 0;
          if (ok) ok = (done_q[0].dev == d);
          check($sformatf("dev%0d done expected", d), int'(ok), 1);
          if (ok) begin
            e = done_q.pop_front();
            check($sformatf("dev%0d done cycle", d), cyc, e.cyc);
          end
        end

        if (m_busy[d] !== prev_busy[d]) begin
          ok = busy_q.size() > 0;
          if (ok) ok = (busy_q[0].dev == d);
          check($sformatf("dev%0d busy edge expected", d), int'(ok), 1);
          if (ok) begin
            e = busy_q.pop_front();
            check($sformatf("dev%0d busy level", d), int'(m_busy[d]), e.val);
            check($sformatf("dev%0d busy edge cycle", d), cyc, e.cyc);
          end
        end
        prev_busy[d] = m_busy[d];
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_both(input int a, input int v);
    bus_a.wr_en = 1'b1; bus_a.wr_addr = TB_AW'(a); bus_a.wr_data = 8'(v);
    bus_b.wr_en = 1'b1; bus_b.wr_addr = TB_AW'(a); bus_b.wr_data = 8'(v);
    step();
    bus_a.wr_en = 1'b0;
    bus_b.wr_en = 1'b0;
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, " pixel"},       int'(bus_a.pixel),       0);
    check({tag, " pixel_valid"}, int'(bus_a.pixel_valid), 0);
    check({tag, " line_end"},    int'(bus_a.line_end),    0);
    check({tag, " frame_end"},   int'(bus_a.frame_end),   0);
    check({tag, " busy"},        int'(bus_a.busy),        0);
    check({tag, " done"},        int'(bus_a.done),        0);
  endtask

  initial begin
    int t0;
    prev_busy[0] = 1'b0; prev_busy[1] = 1'b0;
    last_pix[0]  = 8'd0; last_pix[1]  = 8'd0;
    reset = 1'b1;
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.start = 1'b0; bus_a.pause = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.start = 1'b0; bus_b.pause = 1'b0;
    repeat (3) step();
    mon_on = 1'b1;
    check_idle_a("reset");
    check("reset dev1 busy", int'(bus_b.busy), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < NPIX; i++) write_both(i, i + 16);
    write_both(16, 8'hEE);  // low bits alias address 0
    write_both(12, 8'hEE);

    // Plain frame: pixels at t0+2..5, 8..11, 14..17, done at t0+18.
    t0 = cyc;
    push_frame(0, t0, HB_A, NPIX, 0, NPIX);
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    repeat (24) step();

    // Pause for three cycles where the third pixel would be issued.
    t0 = cyc;
    push_frame(0, t0, HB_A, 2, 3, NPIX);
    for (int k = 0; k < 26; k++) begin
      bus_a.start = (k == 0);
      bus_a.pause = (k >= 3 && k <= 5);
      step();
    end

    // Write and restart while busy: both ignored.
    t0 = cyc;
    push_frame(0, t0, HB_A, NPIX, 0, NPIX);
    bus_a.wr_addr = TB_AW'(5);
    bus_a.wr_data = 8'hFF;
    for (int k = 0; k < 24; k++) begin
      bus_a.start = (k == 0 || (k >= 4 && k <= 6));
      bus_a.wr_en = (k == 5);
      step();
    end
    bus_a.wr_en = 1'b0;
    t0 = cyc;
    push_frame(0, t0, HB_A, NPIX, 0, NPIX);
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    repeat (24) step();

    // Reset while pixel 22 is on the output, then replay from a fresh start.
    t0 = cyc;
    push_frame(0, t0, HB_A, NPIX, 0, 7);
    for (int k = 0; k < 16; k++) begin
      bus_a.start = (k == 0);
      reset       = (k == 10);
      if (k == 11) check_idle_a("after mid-frame reset");
      step();
    end
    t0 = cyc;
    push_frame(0, t0, HB_A, NPIX, 0, NPIX);
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    repeat (24) step();

    // HBLANK=0 with start held: frames 14 cycles apart, contiguous lines.
    t0 = cyc;
    push_frame(1, t0, HB_B, NPIX, 0, NPIX);
    push_frame(1, t0 + 14, HB_B, NPIX, 0, NPIX);
    for (int k = 0; k < 34; k++) begin
      bus_b.start = (k <= 14);
      step();
    end
    repeat (4) step();

    check("pixels left unseen", int'(pix_q.size()), 0);
    check("done pulses left unseen", int'(done_q.size()), 0);
    check("busy edges left unseen", int'(busy_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_streamer.md
Name: pixel_streamer

Overview:
Frame-memory pixel source that drives the raster pixel stream consumed by the Harris pipeline's window builder. A host loads a WIDTH×HEIGHT 8-bit grayscale frame through a write port. On start, the block replays the frame in raster order as pixel/pixel_valid, inserting programmable horizontal blanking between lines. It is the transmitter for the detector's pixel input, used both in simulation benches and as an on-chip test-pattern source.

Parameters:
WIDTH, 64, pixels per line (≥2)
HEIGHT, 64, lines per frame (≥2)
HBLANK, 4, idle cycles inserted after every line except the last (0 allowed)
ADDR_W, 12, frame-memory address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
wr_en  in  1  frame-memory write strobe
wr_addr  in  ADDR_W  write address, raster index y*WIDTH+x
wr_data  in  8  pixel value to store
start  in  1  begin streaming one frame (single-cycle pulse or level)
pause  in  1  stall request; freezes stream position while high
pixel  out  8  streamed pixel value
pixel_valid  out  1  pixel is valid this cycle
line_end  out  1  high with the last pixel of each line (x=WIDTH-1)
frame_end  out  1  high with the final pixel of the frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the frame completes

Behaviour:
- Reset: pixel=0, pixel_valid=0, line_end=0, frame_end=0, busy=0, done=0; FSM→IDLE; x/y/blank counters=0. Memory contents are not cleared. Reset mid-frame aborts immediately with no done pulse.
- Memory: WIDTH*HEIGHT×8, synchronous write, synchronous read with 1-cycle latency. All outputs are registered.
- Writes are accepted only when busy=0. wr_en while busy=1 is ignored and memory is unchanged. wr_addr ≥ WIDTH*HEIGHT is ignored.
- FSM states: IDLE, STREAM, BLANK, FINISH.
  - IDLE: if start=1 at edge N, go to STREAM with x=y=0; busy=1 from N+1.
  - STREAM: each cycle with pause=0, issue a read at y*WIDTH+x and advance x. The corresponding pixel appears one cycle later with pixel_valid=1. The first pixel_valid is at edge N+2 after start is sampled at edge N.
  - At x=WIDTH-1: if y<HEIGHT-1 and HBLANK>0, go to BLANK; if y<HEIGHT-1 and HBLANK=0, go directly to the next line. If y=HEIGHT-1, go to FINISH.
  - BLANK: count HBLANK cycles with no reads issued, then return to STREAM with x=0, y+1. pixel_valid is low for exactly HBLANK cycles between the last pixel of a line and the first pixel of the next (absent pause).
  - FINISH: the final pixel (with line_end=1 and frame_end=1) is output. On the following cycle: busy=0, done=1 for one cycle, FSM returns to IDLE.
- pause=1: no read is issued and x/y/blank counters hold. pixel_valid is 0 on the next cycle. Any already-issued read still emerges, so at most one pixel_valid follows the cycle pause rises. Resuming continues with the exact next pixel; no pixels are lost or duplicated.
- line_end and frame_end are asserted only together with pixel_valid=1. When pixel_valid=0, the pixel output holds its last value.
- start while busy=1 is ignored. start in the same cycle as done returns the FSM to STREAM on the next edge, so frames can run back-to-back.
- Counters: x is ⌈log2 WIDTH⌉ bits, y is ⌈log2 HEIGHT⌉ bits. Both wrap to 0 only via frame restart, never modulo.

Test Plan:
- Use WIDTH=4, HEIGHT=3, HBLANK=2. Load mem[i]=i+16 for i=0..11, pulse start at cycle 10. Required: pixel_valid at cycles 12–15 with pixels 16–19; gap at 16–17; pixels 20–23 at 18–21; gap at 22–23; pixels 24–27 at 24–27. line_end at 15, 21, 27; frame_end at 27; done=1 only at 28; busy=1 from 11–27.
- Same frame with pause high for 3 cycles starting at the cycle the third pixel (18) is issued. Required: the output sequence is still exactly 16..27, with no duplicates or drops. Total frame duration grows by 3 cycles.
- During busy, issue a write of 0xFF to address 5 and assert start again. Required: the stream is unchanged (address 5 still outputs 21) and no second frame starts. A rerun after done also shows 21 at address 5.
- Assert reset at the cycle pixel 22 is output. Required: next cycle all outputs are 0, no done pulse, FSM in IDLE. A new start replays 16..27 from the beginning, proving memory is intact.
- With HBLANK=0, hold start continuously high. Required: frames run back-to-back and each line is contiguous. done pulses for one cycle and the next frame's first pixel appears 2 cycles after done.
